// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam int          FETCH_PC_W  = 64;
    localparam int          FETCH_IN_W  = 32;
    localparam logic [10:0] HALT_OPCODE = 11'h7FF;

    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [FETCH_IN_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Memory-side and decode-side signals of the fetch queue unit.
interface fetch_queue_unit_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               branch_valid;
    logic [ADDR_W-1:0]  branch_target;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               halted;

    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_instr, halted,
        input  imem_rdata, branch_valid, branch_target, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_instr, halted,
        output imem_rdata, branch_valid, branch_target, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries; flush wins over push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_data,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_push  = push && !flush;
        do_pop   = pop && (count_q != '0) && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = nxt(wr_ptr_q);
            if (do_pop)  rd_ptr_d = nxt(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: sequential PC generation, imem reads, prefetch queue to decode.
// Define FQU_STATS_EN to add fetch_count / flush_count statistics ports.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 64,
    parameter int              INSTR_W  = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_queue_unit_if.master bus
`ifdef FQU_STATS_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       flush_count
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic              drop_q, drop_d;
    logic              halted_q, halted_d;
    logic              req, push, pop, is_halt;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      push_data, head;

    always_comb begin
        // Occupancy plus the outstanding read must leave room for it to land.
        req     = !reset && !halted_q && !bus.branch_valid &&
                  ((int'(count) + int'(inflight_q)) < DEPTH);
        push    = inflight_q && !drop_q && !bus.branch_valid;
        pop     = bus.out_valid && bus.out_ready;
        is_halt = push && (bus.imem_rdata[INSTR_W-1 -: 11] == HALT_OPCODE);

        push_data.pc    = FETCH_PC_W'(addr_q);
        push_data.instr = bus.imem_rdata;

        pc_d       = pc_q;
        addr_d     = addr_q;
        inflight_d = req;
        drop_d     = is_halt;
        halted_d   = halted_q || is_halt;
        if (req) begin
            pc_d   = pc_q + ADDR_W'(INSTR_BYTES);
            addr_d = pc_q;
        end
        if (bus.branch_valid) begin
            pc_d     = bus.branch_target & ~ADDR_W'(3);
            drop_d   = 1'b0;
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            halted_q   <= halted_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (bus.branch_valid),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

    // addr_q doubles as the PC of the read currently in flight.
    assign bus.imem_req  = req;
    assign bus.imem_addr = req ? pc_q : addr_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = head.pc[ADDR_W-1:0];
    assign bus.out_instr = head.instr[INSTR_W-1:0];
    assign bus.halted    = halted_q;

`ifdef FQU_STATS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(pop);
        flush_cnt_d = flush_cnt_q + 32'(bus.branch_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`endif
endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction fetch stage with a prefetch queue, placed between instruction memory and InstructionDecode. It generates sequential PCs, issues word reads to a synchronous instruction memory port, and buffers {PC, instruction} pairs in a FIFO. Decode consumes entries through a valid/ready handshake. The unit handles branch redirects with a queue flush, and stops fetching after a HALT opcode.

## Interface
- `ADDR_W`, 64: PC / byte-address width.
- `INSTR_W`, 32: instruction width. Fixed at 4 bytes per fetch.
- `DEPTH`, 4: queue entries. Minimum 2. Full one-per-cycle throughput needs ≥3.
- `RESET_PC`, 0: PC loaded at reset.
- `clk  in  1`: the single clock. All state changes on its rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `imem_req  out  1`: read issued this cycle.
- `imem_addr  out  ADDR_W`: byte address of the read. Always 4-aligned.
- `imem_rdata  in  INSTR_W`: read data, valid exactly one cycle after `imem_req`.
- `branch_valid  in  1`: redirect request (PCSrc).
- `branch_target  in  ADDR_W`: redirect address (BranchAddress). Bits [1:0] are ignored and forced to 0.
- `out_valid  out  1`: queue head is valid.
- `out_ready  in  1`: decode accepts the head.
- `out_pc  out  ADDR_W`: PC of the head entry.
- `out_instr  out  INSTR_W`: instruction of the head entry.
- `halted  out  1`: HALT has been enqueued, and fetching is stopped.
- `fetch_count  out  32`: present only with `FQU_STATS_EN`.
- `flush_count  out  32`: present only with `FQU_STATS_EN`.

## Operation
- **Issue rule.** `imem_req`=1 when all of the following hold; on each issue, the fetch PC increments by 4 (mod 2^ADDR_W):
  - not `halted`;
  - no `branch_valid` this cycle;
  - no redirect in the previous cycle is still pending;
  - occupancy + in-flight < DEPTH, with occupancy sampled at cycle start and a same-cycle pop ignored.
- **Queue full.** The issue rule guarantees that a response never arrives to a full queue.
- **Response.** The cycle after an issue, `imem_rdata` is enqueued together with the PC that was issued, unless a drop flag is set.
- **Pop.** `out_valid && out_ready` removes the head. The queue is FIFO: order always equals issue order.
- **Redirect.** On `branch_valid`:
  - occupancy is cleared;
  - any in-flight response is dropped;
  - PC is set to the aligned `branch_target`;
  - `halted` is cleared.
  - A handshake in the same cycle completes normally: that entry counts as delivered.
- **HALT.** HALT is detected when an enqueued instruction has [31:21]==11'h7FF.
  - The HALT entry is enqueued and delivered normally.
  - `halted` sets at the next edge.
  - A response arriving in the cycle after the HALT enqueue is dropped.
  - `halted` clears only on `reset` or `branch_valid`.
- **Reset.** Reset values:
  - PC=RESET_PC;
  - queue empty, in-flight=0, drop flag=0;
  - `imem_req`=0, `out_valid`=0, `halted`=0, counters=0.
  - Reset asserted mid-operation discards everything at that edge.

## Timing
- Cycle 1 is the first cycle with `reset`=0.
  - Cycle 1: `imem_req`=1 with addr RESET_PC.
  - Cycle 2: data arrives.
  - Cycle 3: `out_valid`=1.
- No FIFO bypass. Fetch-to-output latency is 2 cycles after request.
- Redirect at cycle t:
  - `imem_req` is low at t;
  - the target is requested at t+1;
  - the target entry appears on the outputs at t+3.
- With DEPTH≥3 and `out_ready` held at 1, one entry is delivered per cycle.
- Outputs `out_*` are registered from queue storage. `imem_addr` holds its value while `imem_req`=0.

## Configuration
- `FQU_STATS_EN` defined:
  - `fetch_count` increments on every output handshake.
  - `flush_count` increments on every `branch_valid` cycle.
  - Both are 32-bit, wrap silently, and reset to 0.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `fetch_pkg` contains:
  - `HALT_OPCODE` = 11'h7FF;
  - `fetch_entry_t` = {pc, instr}, packed to 96 bits for ADDR_W=64;
  - `INSTR_BYTES` = 4.
- Sub-module `fetch_fifo`: a synchronous FIFO with push, pop, a flush input, and an occupancy output. `flush` has priority over push; a pop in the same cycle as a flush is harmless.
- The top level holds the PC register, in-flight/drop flags, `halted`, and the optional counters.

## Test plan
- **Reset and sequential fetch.** Memory model returns instr=addr; `out_ready`=1. Expect `out_valid` first at cycle 3, then `out_pc` 0, 4, 8, 12… with `out_instr`==`out_pc`, and no gaps (DEPTH=4).
- **Backpressure.** `out_ready`=0 for 10 cycles. Expect exactly 4 requests, then `imem_req`=0. On release, expect `out_pc` 0, 4, 8, 12, 16 in order, with no duplicates.
- **Redirect.** Queue holds 3 entries and one read is in flight; pulse `branch_valid` with target 0x102. Expect the next delivered `out_pc`=0x100, the next `imem_addr`=0x100 one cycle later, and no stale entry delivered.
- **HALT.** Word at 0x10 is 0xFFE00000. Expect entries 0x0–0x10 delivered, `halted`=1, `imem_req` held at 0 afterwards, and 0x14 never delivered. A subsequent `branch_valid` to 0x40 clears `halted` and delivers 0x40.
- **Simultaneous redirect and handshake.** `branch_valid` and a handshake in the same cycle: that head counts as delivered, and the following head is the target.
- **Reset mid-run.** With 3 entries queued, assert `reset` for 1 cycle. Expect `out_valid`=0 the next cycle and refetch from RESET_PC. With `FQU_STATS_EN`, counters read 0 after reset, then match the handshake and redirect counts.
